debounce_bank: RTL and testbench

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_bank_pkg.sv | 17 +
 rtl/debounce_channel.sv | 115 +++++++++++
 rtl/debounce_bank.sv | 46 ++++
 tb/tb_debounce_bank.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_bank_pkg.sv
// Shared definitions for the debounce bank: per-channel FSM state encoding
// and the legal range of the input synchroniser depth.
package debounce_bank_pkg;

  // Per-channel debounce FSM states (2-bit encoding, all codes used).
  typedef enum logic [1:0] {
    STABLE_0 = 2'b00,
    PEND_1   = 2'b01,
    STABLE_1 = 2'b10,
    PEND_0   = 2'b11
  } state_e;

  // Synchroniser depth bounds; out-of-range requests are clamped.
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: input synchroniser, 4-state debounce FSM with a
// down-counter, registered level and edge pulses. rise_nxt/fall_nxt expose
// the next-cycle pulse values so the top can register any_event in step.
module debounce_channel
  import debounce_bank_pkg::*;
#(
  parameter int CNT_WIDTH   = 19,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 raw,
  input  logic [CNT_WIDTH-1:0] thresh,
  output logic                 q,
  output logic                 rise,
  output logic                 fall,
  output logic                 rise_nxt,
  output logic                 fall_nxt
);

  localparam int DEPTH = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                         (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX :
                         SYNC_STAGES;

  logic [DEPTH-1:0]     sync_q;
  logic                 s;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] load_val;
  logic                 q_d;

  assign s = sync_q[DEPTH-1];

  // thresh of 0 is treated as 1, so the load value never underflows.
  assign load_val = (thresh == '0) ? '0 : thresh - CNT_WIDTH'(1);

  // Synchronise the asynchronous raw input into the clk domain.
  // NOTE: the synchroniser flops are reset as well, so s is a defined 0
  // straight out of reset instead of whatever the pad happened to hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[DEPTH-2:0], raw};
  end

  // FSM next-state, counter and output decode.
  // NOTE: every signal gets a default before the case; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    q_d      = q;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    case (state_q)
      STABLE_0: begin
        if (s) begin
          state_d = PEND_1;
          cnt_d   = load_val;
        end
      end
      PEND_1: begin
        if (!s) begin
          state_d = STABLE_0;
        end else if (cnt_q == '0) begin
          state_d  = STABLE_1;
          q_d      = 1'b1;
          rise_nxt = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      STABLE_1: begin
        if (!s) begin
          state_d = PEND_0;
          cnt_d   = load_val;
        end
      end
      PEND_0: begin
        if (s) begin
          state_d = STABLE_1;
        end else if (cnt_q == '0) begin
          state_d  = STABLE_0;
          q_d      = 1'b0;
          fall_nxt = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = STABLE_0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STABLE_0;
      cnt_q   <= '0;
      q       <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q       <= q_d;
      rise    <= rise_nxt;
      fall    <= fall_nxt;
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounce channels sharing one threshold, plus a
// registered any_event flag aligned with the per-channel rise/fall pulses.
module debounce_bank
  import debounce_bank_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CNT_WIDTH   = 19,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CHANNELS-1:0]  raw,
  input  logic [CNT_WIDTH-1:0] thresh,
  output logic [CHANNELS-1:0]  q,
  output logic [CHANNELS-1:0]  rise,
  output logic [CHANNELS-1:0]  fall,
  output logic                 any_event
);

  logic [CHANNELS-1:0] rise_nxt;
  logic [CHANNELS-1:0] fall_nxt;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .CNT_WIDTH  (CNT_WIDTH),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .raw     (raw[i]),
      .thresh  (thresh),
      .q       (q[i]),
      .rise    (rise[i]),
      .fall    (fall[i]),
      .rise_nxt(rise_nxt[i]),
      .fall_nxt(fall_nxt[i])
    );
  end

  // Register the OR of the next-cycle pulses so any_event lines up with them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) any_event <= 1'b0;
    else       any_event <= |(rise_nxt | fall_nxt);
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed self-checking bench for debounce_bank (CHANNELS=4, CNT_WIDTH=8,
// SYNC_STAGES=2). Inputs are driven and outputs sampled on the falling edge.
module tb_debounce_bank;
  import debounce_bank_pkg::*;

  localparam int CH = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] raw;
  logic [CW-1:0] thresh;
  logic [CH-1:0] q, rise, fall;
  logic          any_event;

  int total = 0;
  int bad   = 0;

  debounce_bank #(
    .CHANNELS   (CH),
    .CNT_WIDTH  (CW),
    .SYNC_STAGES(2)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .raw      (raw),
    .thresh   (thresh),
    .q        (q),
    .rise     (rise),
    .fall     (fall),
    .any_event(any_event)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then park on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int nrise;
    int nfall;
    int redge;

    reset  = 1'b1;
    raw    = '0;
    thresh = 8'd4;
    @(negedge clk);
    tick();

    // Reset state.
    check("rst_q",    32'(q),         32'(0));
    check("rst_rise", 32'(rise),      32'(0));
    check("rst_fall", 32'(fall),      32'(0));
    check("rst_any",  32'(any_event), 32'(0));
    check("rst_st0",  32'(u_dut.g_ch[0].u_ch.state_q), 32'(STABLE_0));
    reset = 1'b0;
    tick();
    tick();

    // Clean rise on ch0, thresh=4: q on the 7th edge counting the sampling edge.
    raw[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("c0_q_e%0d", k),    32'(q[0]),      32'(k >= 7));
      check($sformatf("c0_rise_e%0d", k), 32'(rise[0]),   32'(k == 7));
      check($sformatf("c0_any_e%0d", k),  32'(any_event), 32'(k == 7));
    end

    // 3-cycle glitch on ch1 is rejected.
    raw[1] = 1'b1;
    repeat (3) tick();
    raw[1] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("glitch_q_e%0d", k),    32'(q[1]),    32'(0));
      check($sformatf("glitch_rise_e%0d", k), 32'(rise[1]), 32'(0));
    end
    check("glitch_state", 32'(u_dut.g_ch[1].u_ch.state_q), 32'(STABLE_0));
    check("glitch_q0_kept", 32'(q[0]), 32'(1));

    // ch2 toggles every 2 cycles for 40 cycles, then holds 1.
    nrise = 0;
    nfall = 0;
    redge = 0;
    for (int k = 1; k <= 60; k++) begin
      if (k <= 40) raw[2] = (((k - 1) >> 1) & 1) == 0;
      else         raw[2] = 1'b1;
      tick();
      if (rise[2]) begin
        nrise++;
        redge = k;
      end
      if (fall[2]) nfall++;
    end
    check("bounce_nrise", 32'(nrise), 32'(1));
    check("bounce_edge",  32'(redge), 32'(47));
    check("bounce_nfall", 32'(nfall), 32'(0));
    check("bounce_q",     32'(q[2]),  32'(1));

    // thresh changes 4->200 mid PEND_1 on ch3; count in progress is unaffected.
    raw[3] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 4) thresh = 8'd200;
      if (k == 6) check("thr_q_e6", 32'(q[3]), 32'(0));
      if (k == 7) begin
        check("thr_q_e7",    32'(q[3]),    32'(1));
        check("thr_rise_e7", 32'(rise[3]), 32'(1));
      end
    end
    raw[3] = 1'b0;
    for (int k = 1; k <= 203; k++) begin
      tick();
      if (k == 7)   check("thr200_fall_e7", 32'(fall[3]), 32'(0));
      if (k == 202) check("thr200_q_e202",  32'(q[3]),    32'(1));
      if (k == 203) begin
        check("thr200_q_e203",    32'(q[3]),    32'(0));
        check("thr200_fall_e203", 32'(fall[3]), 32'(1));
      end
    end

    // All channels together.
    thresh = 8'd4;
    raw    = 4'b0000;
    repeat (12) tick();
    check("all_q_low", 32'(q), 32'(0));
    raw = 4'b1111;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) check("all_rise_e6", 32'(rise), 32'(0));
    end
    check("all_rise", 32'(rise),      32'(4'b1111));
    check("all_fall0", 32'(fall),     32'(0));
    check("all_any",  32'(any_event), 32'(1));
    raw = 4'b0000;
    repeat (7) tick();
    check("all_fall",  32'(fall),      32'(4'b1111));
    check("all_rise0", 32'(rise),      32'(0));
    check("all_any2",  32'(any_event), 32'(1));
    tick();
    check("all_any_off", 32'(any_event), 32'(0));

    // Reset mid-count (cnt=2 in PEND_1 on ch0) while q[3]=1.
    raw = 4'b1000;
    repeat (10) tick();
    check("pre_rst_q", 32'(q), 32'(4'b1000));
    raw = 4'b1001;
    repeat (4) tick();
    check("pre_rst_cnt", 32'(u_dut.g_ch[0].u_ch.cnt_q), 32'(2));
    reset = 1'b1;
    #1;
    check("mid_rst_q",    32'(q),         32'(0));
    check("mid_rst_rise", 32'(rise),      32'(0));
    check("mid_rst_any",  32'(any_event), 32'(0));
    check("mid_rst_st",   32'(u_dut.g_ch[0].u_ch.state_q), 32'(STABLE_0));
    check("mid_rst_cnt",  32'(u_dut.g_ch[0].u_ch.cnt_q),   32'(0));
    repeat (2) tick();
    check("in_rst_rise", 32'(rise), 32'(0));
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("post_rst_rise_e%0d", k), 32'(rise),
            (k == 7) ? 32'(4'b1001) : 32'(0));
      check($sformatf("post_rst_q_e%0d", k), 32'(q),
            (k >= 7) ? 32'(4'b1001) : 32'(0));
    end

    // thresh=0 and thresh=1 both give latency 2+1+1=4.
    for (int th = 0; th <= 1; th++) begin
      reset = 1'b1;
      raw   = '0;
      tick();
      thresh = CW'(th);
      reset  = 1'b0;
      tick();
      tick();
      raw = 4'b1111;
      for (int k = 1; k <= 5; k++) begin
        tick();
        check($sformatf("th%0d_q_e%0d", th, k), 32'(q),
              (k >= 4) ? 32'(4'b1111) : 32'(0));
        check($sformatf("th%0d_rise_e%0d", th, k), 32'(rise),
              (k == 4) ? 32'(4'b1111) : 32'(0));
      end
      raw = 4'b0000;
      for (int k = 1; k <= 5; k++) begin
        tick();
        check($sformatf("th%0d_fq_e%0d", th, k), 32'(q),
              (k >= 4) ? 32'(0) : 32'(4'b1111));
        check($sformatf("th%0d_fall_e%0d", th, k), 32'(fall),
              (k == 4) ? 32'(4'b1111) : 32'(0));
      end
    end

    // All-ones threshold: latency 2+255+1=258, no wrap.
    thresh = 8'hFF;
    raw[1] = 1'b1;
    for (int k = 1; k <= 258; k++) begin
      tick();
      if (k == 257) check("max_q_e257", 32'(q[1]), 32'(0));
      if (k == 258) begin
        check("max_q_e258",    32'(q[1]),    32'(1));
        check("max_rise_e258", 32'(rise[1]), 32'(1));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
